// File: rtl/mem_max_scanner.sv
// mem_max_scanner: second data-memory master; scans len words for the signed max and its first index.
// Done in cycle len+1 after start (len+3 with MEM_MAX_SCANNER_WRITEBACK_EN, 1 when len=0); no backpressure, start ignored while busy.
module mem_max_scanner #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] len,
  input  logic [DATA_W-1:0] res_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_value,
  output logic [DATA_W-1:0] max_index,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
);

  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
  localparam logic [DATA_W-1:0] EMPTY_MAX = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] EMPTY_IDX = {DATA_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WB_MAX,
    S_WB_IDX,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_base;
  logic [DATA_W-1:0] r_len;
  logic [DATA_W-1:0] r_i;
  logic [DATA_W-1:0] r_max_value;
  logic [DATA_W-1:0] r_max_index;
  logic              w_last;
  logic              w_take;

`ifdef MEM_MAX_SCANNER_WRITEBACK_EN
  logic [DATA_W-1:0] r_res_addr;
`else
  logic              w_unused_res_addr;
  assign w_unused_res_addr = ^res_addr;
`endif

  assign w_last    = (r_i == (r_len - ONE));
  // First word always seeds the running max; later words must be strictly larger so ties keep the lower index.
  assign w_take    = (r_i == '0) || ($signed(ReadData) > $signed(r_max_value));
  assign max_value = r_max_value;
  assign max_index = r_max_index;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (len == '0) ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        busy    = 1'b1;
        MemRead = 1'b1;
        Address = r_base + r_i;
        if (w_last) begin
`ifdef MEM_MAX_SCANNER_WRITEBACK_EN
          w_next = S_WB_MAX;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef MEM_MAX_SCANNER_WRITEBACK_EN
      S_WB_MAX: begin
        busy      = 1'b1;
        MemWrite  = 1'b1;
        Address   = r_res_addr;
        WriteData = r_max_value;
        w_next    = S_WB_IDX;
      end
      S_WB_IDX: begin
        busy      = 1'b1;
        MemWrite  = 1'b1;
        Address   = r_res_addr + ONE;
        WriteData = r_max_index;
        w_next    = S_DONE;
      end
`endif
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_base      <= '0;
      r_len       <= '0;
      r_i         <= '0;
      r_max_value <= '0;
      r_max_index <= '0;
`ifdef MEM_MAX_SCANNER_WRITEBACK_EN
      r_res_addr  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base <= base;
            r_len  <= len;
            r_i    <= '0;
`ifdef MEM_MAX_SCANNER_WRITEBACK_EN
            r_res_addr <= res_addr;
`endif
            if (len == '0) begin
              r_max_value <= EMPTY_MAX;
              r_max_index <= EMPTY_IDX;
            end
          end
        end
        S_SCAN: begin
          if (w_take) begin
            r_max_value <= ReadData;
            r_max_index <= r_i;
          end
          r_i <= r_i + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_max_scanner.sv
// Bench for mem_max_scanner: 256-word memory model aliased on Address[7:0], reference max/index
// model computed directly from memory contents, directed scenarios plus randomized scans.
module tb_mem_max_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base, len, res_addr;
  logic        busy, done, MemRead, MemWrite;
  logic [31:0] max_value, max_index, Address, WriteData, ReadData;

  logic [31:0] mem [256];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [31:0] q_rd [$];
  logic [31:0] q_wa [$];
  logic [31:0] q_wd [$];
  int          q_wc [$];
  int          n_done = 0;
  int          n_both = 0;

  int rd0, wr0, dn0, bh0;

  always #5 clk = ~clk;

  assign ReadData = MemRead ? mem[Address[7:0]] : 32'h0;

  mem_max_scanner #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .len       (len),
    .res_addr  (res_addr),
    .busy      (busy),
    .done      (done),
    .max_value (max_value),
    .max_index (max_index),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (MemRead === 1'b1) q_rd.push_back(Address);
    if (MemWrite === 1'b1) begin
      q_wa.push_back(Address);
      q_wd.push_back(WriteData);
      q_wc.push_back(cyc);
    end
    if (done === 1'b1) n_done++;
    if (MemRead === 1'b1 && MemWrite === 1'b1) n_both++;
  end

  function automatic int exp_lat(input int l);
    if (l == 0) return 1;
`ifdef MEM_MAX_SCANNER_WRITEBACK_EN
    return l + 3;
`else
    return l + 1;
`endif
  endfunction

  // Reference: first occurrence of the largest signed word among mem[base+k], k < len.
  function automatic void ref_scan(input logic [31:0] b, input logic [31:0] l,
                                   output logic [31:0] mv, output logic [31:0] mi);
    logic [31:0] a;
    int best;
    mv = 32'h8000_0000;
    mi = 32'hFFFF_FFFF;
    best = -1;
    for (int k = 0; k < int'(l); k++) begin
      a = b + 32'(k);
      if (best < 0 || $signed(mem[a[7:0]]) > $signed(mv)) begin
        mv   = mem[a[7:0]];
        mi   = 32'(k);
        best = k;
      end
    end
  endfunction

  task automatic snap();
    rd0 = q_rd.size();
    wr0 = q_wa.size();
    dn0 = n_done;
    bh0 = n_both;
  endtask

  // Issues one scan, scrambles the inputs after acceptance, and returns the done cycle (-1 on timeout).
  task automatic run_scan(input logic [31:0] b, input logic [31:0] l, input logic [31:0] r,
                          output int dc);
    snap();
    base = b; len = l; res_addr = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base = $urandom; len = $urandom; res_addr = $urandom;
    dc = -1;
    for (int k = 1; k <= int'(l) + 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = k;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; base = 32'h0; len = 32'h0; res_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, MemRead, MemWrite, max_value, max_index, Address, WriteData} !== 100'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b mv=%h mi=%h a=%h wd=%h want all zero",
               busy, done, MemRead, MemWrite, max_value, max_index, Address, WriteData);
    end
    rst = 1'b1; start = 1'b1; len = 32'h0; base = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_first_start: got busy=%b done=%b want 1 1", busy, done);
    end
    vectors++;
    if (max_value !== 32'h8000_0000 || max_index !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL reset_len0_result: got %h/%h want 80000000/ffffffff", max_value, max_index);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int dc, bad;
    mem[100] = 32'd3; mem[101] = 32'hFFFF_FFFB; mem[102] = 32'd9; mem[103] = 32'd9;
    run_scan(32'd100, 32'd4, 32'd200, dc);
    vectors++;
    if (dc !== exp_lat(4)) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d want %0d", dc, exp_lat(4));
    end
    vectors++;
    if (q_rd.size() - rd0 !== 4) begin
      miscompares++;
      $display("FAIL basic_read_count: got %0d want 4", q_rd.size() - rd0);
    end
    bad = 0;
    for (int k = 0; k < 4 && rd0 + k < q_rd.size(); k++)
      if (q_rd[rd0 + k] !== 32'd100 + 32'(k)) bad++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL basic_addresses: got %0d wrong addresses want 0", bad);
    end
    vectors++;
    if (max_value !== 32'd9 || max_index !== 32'd2) begin
      miscompares++;
      $display("FAIL basic_result: got %0d/%0d want 9/2", max_value, max_index);
    end
    vectors++;
    if (busy !== 1'b0 || n_done - dn0 !== 1 || n_both - bh0 !== 0) begin
      miscompares++;
      $display("FAIL basic_status: got busy=%b dones=%0d overlap=%0d want 0 1 0", busy, n_done - dn0, n_both - bh0);
    end
`ifdef MEM_MAX_SCANNER_WRITEBACK_EN
    vectors++;
    if (q_wa.size() - wr0 !== 2) begin
      miscompares++;
      $display("FAIL basic_wb_count: got %0d want 2", q_wa.size() - wr0);
    end else begin
      vectors++;
      if (q_wa[wr0] !== 32'd200 || q_wd[wr0] !== 32'd9 || q_wa[wr0+1] !== 32'd201 || q_wd[wr0+1] !== 32'd2) begin
        miscompares++;
        $display("FAIL basic_wb_data: got [%0d]=%0d [%0d]=%0d want [200]=9 [201]=2",
                 q_wa[wr0], q_wd[wr0], q_wa[wr0+1], q_wd[wr0+1]);
      end
      vectors++;
      if (q_wc[wr0+1] - q_wc[wr0] !== 1) begin
        miscompares++;
        $display("FAIL basic_wb_spacing: got %0d cycles want 1", q_wc[wr0+1] - q_wc[wr0]);
      end
    end
`else
    vectors++;
    if (q_wa.size() - wr0 !== 0) begin
      miscompares++;
      $display("FAIL basic_no_write: got %0d writes want 0", q_wa.size() - wr0);
    end
`endif
  endtask

  task automatic test_signed();
    int dc;
    mem[0] = 32'hFFFF_FFF9; mem[1] = 32'hFFFF_FFFE; mem[2] = 32'hFFFF_FFF7;
    run_scan(32'd0, 32'd3, 32'd50, dc);
    vectors++;
    if (max_value !== 32'hFFFF_FFFE || max_index !== 32'd1) begin
      miscompares++;
      $display("FAIL signed_result: got %h/%0d want fffffffe/1", max_value, max_index);
    end
    vectors++;
    if (dc !== exp_lat(3)) begin
      miscompares++;
      $display("FAIL signed_latency: got %0d want %0d", dc, exp_lat(3));
    end
  endtask

  task automatic test_len0();
    int dc;
    run_scan(32'd7, 32'd0, 32'd60, dc);
    vectors++;
    if (dc !== 1) begin
      miscompares++;
      $display("FAIL len0_latency: got %0d want 1", dc);
    end
    vectors++;
    if (q_rd.size() - rd0 !== 0 || q_wa.size() - wr0 !== 0) begin
      miscompares++;
      $display("FAIL len0_no_access: got %0d reads %0d writes want 0 0", q_rd.size() - rd0, q_wa.size() - wr0);
    end
    vectors++;
    if (max_value !== 32'h8000_0000 || max_index !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL len0_result: got %h/%h want 80000000/ffffffff", max_value, max_index);
    end
  endtask

  task automatic test_wrap();
    int dc, n;
    mem[254] = 32'd1; mem[255] = 32'd2; mem[0] = 32'd5;
    run_scan(32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, dc);
    n = q_rd.size() - rd0;
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL wrap_read_count: got %0d want 3", n);
    end else begin
      vectors++;
      if (q_rd[rd0] !== 32'hFFFF_FFFE || q_rd[rd0+1] !== 32'hFFFF_FFFF || q_rd[rd0+2] !== 32'h0) begin
        miscompares++;
        $display("FAIL wrap_addresses: got %h %h %h want fffffffe ffffffff 00000000",
                 q_rd[rd0], q_rd[rd0+1], q_rd[rd0+2]);
      end
    end
    vectors++;
    if (max_value !== 32'd5 || max_index !== 32'd2) begin
      miscompares++;
      $display("FAIL wrap_result: got %0d/%0d want 5/2", max_value, max_index);
    end
`ifdef MEM_MAX_SCANNER_WRITEBACK_EN
    vectors++;
    if (q_wa.size() - wr0 !== 2 || q_wa[wr0] !== 32'hFFFF_FFFF || q_wa[wr0+1] !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_wb_addr: got %0d writes want 2 at ffffffff then 00000000", q_wa.size() - wr0);
    end
`endif
  endtask

  task automatic test_random();
    int dc, bad, n, l;
    logic [31:0] b, r, mv, mi;
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < 256; j++)
        mem[j] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'(int'($urandom_range(0, 15)) - 8);
      b = $urandom;
      l = int'($urandom_range(1, 24));
      r = $urandom;
      ref_scan(b, 32'(l), mv, mi);
      run_scan(b, 32'(l), r, dc);
      n = q_rd.size() - rd0;
      bad = 0;
      for (int k = 0; k < n; k++)
        if (q_rd[rd0 + k] !== b + 32'(k)) bad++;
      vectors++;
      if (max_value !== mv || max_index !== mi) begin
        miscompares++;
        $display("FAIL rand_result[%0d]: got %h/%0d want %h/%0d", it, max_value, max_index, mv, mi);
      end
      vectors++;
      if (dc !== exp_lat(l) || n !== l || bad !== 0) begin
        miscompares++;
        $display("FAIL rand_access[%0d]: got lat=%0d reads=%0d badaddr=%0d want lat=%0d reads=%0d badaddr=0",
                 it, dc, n, bad, exp_lat(l), l);
      end
`ifdef MEM_MAX_SCANNER_WRITEBACK_EN
      vectors++;
      if (q_wa.size() - wr0 !== 2 || q_wa[wr0] !== r || q_wd[wr0] !== mv
          || q_wa[wr0+1] !== r + 32'd1 || q_wd[wr0+1] !== mi) begin
        miscompares++;
        $display("FAIL rand_wb[%0d]: got %0d writes want 2 ([%h]=%h [%h]=%h)", it, q_wa.size() - wr0,
                 r, mv, r + 32'd1, mi);
      end
`else
      vectors++;
      if (q_wa.size() - wr0 !== 0) begin
        miscompares++;
        $display("FAIL rand_no_write[%0d]: got %0d writes want 0", it, q_wa.size() - wr0);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2;
    logic [31:0] mv, mi;
    for (int j = 0; j < 256; j++) mem[j] = $urandom;
    run_scan(32'd30, 32'd5, 32'd90, dc1);
    ref_scan(32'd40, 32'd2, mv, mi);
    run_scan(32'd40, 32'd2, 32'd92, dc2);
    vectors++;
    if (dc1 !== exp_lat(5) || dc2 !== exp_lat(2)) begin
      miscompares++;
      $display("FAIL b2b_latency: got %0d %0d want %0d %0d", dc1, dc2, exp_lat(5), exp_lat(2));
    end
    vectors++;
    if (max_value !== mv || max_index !== mi) begin
      miscompares++;
      $display("FAIL b2b_result: got %h/%0d want %h/%0d", max_value, max_index, mv, mi);
    end
  endtask

  task automatic test_abort();
    for (int j = 0; j < 256; j++) mem[j] = $urandom;
    base = 32'd10; len = 32'd10; res_addr = 32'd120; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, MemRead, MemWrite, max_value, max_index, Address, WriteData} !== 100'h0) begin
      miscompares++;
      $display("FAIL abort_outputs: got busy=%b done=%b rd=%b wr=%b mv=%h mi=%h a=%h wd=%h want all zero",
               busy, done, MemRead, MemWrite, max_value, max_index, Address, WriteData);
    end
    snap();
    rst = 1'b1;
    repeat (16) @(negedge clk);
    vectors++;
    if (n_done - dn0 !== 0 || q_rd.size() - rd0 !== 0 || q_wa.size() - wr0 !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_quiet: got dones=%0d reads=%0d writes=%0d busy=%b want 0 0 0 0",
               n_done - dn0, q_rd.size() - rd0, q_wa.size() - wr0, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start();
    int dc, n, bad;
    logic [31:0] mv, mi;
    for (int j = 0; j < 256; j++) mem[j] = $urandom;
    ref_scan(32'd20, 32'd6, mv, mi);
    snap();
    base = 32'd20; len = 32'd6; res_addr = 32'd140; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base = 32'd50; len = 32'd2; res_addr = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    dc = -1;
    for (int k = 3; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = k;
        start = 1'b1; base = 32'd60; len = 32'd3;
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    n = q_rd.size() - rd0;
    bad = 0;
    for (int k = 0; k < n; k++)
      if (q_rd[rd0 + k] !== 32'd20 + 32'(k)) bad++;
    vectors++;
    if (dc !== exp_lat(6)) begin
      miscompares++;
      $display("FAIL ignore_latency: got %0d want %0d", dc, exp_lat(6));
    end
    vectors++;
    if (n !== 6 || bad !== 0 || n_done - dn0 !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_single_scan: got reads=%0d badaddr=%0d dones=%0d busy=%b want 6 0 1 0",
               n, bad, n_done - dn0, busy);
    end
    vectors++;
    if (max_value !== mv || max_index !== mi) begin
      miscompares++;
      $display("FAIL ignore_result: got %h/%0d want %h/%0d", max_value, max_index, mv, mi);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int j = 0; j < 256; j++) mem[j] = 32'h0;
    test_reset();
    test_basic();
    test_signed();
    test_len0();
    test_wrap();
    test_random();
    test_back_to_back();
    test_abort();
    test_ignored_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
